// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand-forwarding select, load-use and mul/div stall control,
// and branch-redirect flush for an in-order 5-stage integer pipeline.
module hazard_ctrl #(
    parameter int REG_ID_W   = 5,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_ID_W-1:0] id_rs1,
    input  logic [REG_ID_W-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_wen,
    input  logic                id_is_load,
    input  logic                id_is_md,
    input  logic                md_done,
    input  logic                ex_redirect,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                stall_if,
    output logic                stall_id,
    output logic                flush_id,
    output logic                bubble_ex,
    output logic [1:0]          state,
    output logic                md_err
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_t;

    // Shadow copy of what each downstream stage holds.
    typedef struct packed {
        logic                valid;
        logic [REG_ID_W-1:0] rd;
        logic                wen;
        logic                is_load;
        logic                is_md;
    } ent_t;

    state_t             r_state;
    ent_t               r_ex, r_mem, r_wb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_md_err;

    logic               w_redir;
    logic               w_ld_use;
    logic               w_md_busy;
    logic               w_run_ld;
    logic               w_run_md;
    logic               w_md_hold;
    logic               w_stall;
    logic               w_allow_ex;
    ent_t               w_id_ent;

    // A stage supplies a source only if it really writes a non-zero register
    // that the ID instruction really reads.
    function automatic logic f_match(ent_t e, logic [REG_ID_W-1:0] src, logic used);
        return used & e.valid & e.wen & (e.rd != '0) & (e.rd == src);
    endfunction

    // Youngest producer wins; a load in EX has no data yet so it is skipped
    // (the load-use stall covers that case).
    function automatic logic [1:0] f_fwd(ent_t ex, ent_t mem, ent_t wb, logic allow_ex,
                                         logic [REG_ID_W-1:0] src, logic used);
        if (allow_ex && f_match(ex, src, used) && !ex.is_load) return 2'b01;
        else if (f_match(mem, src, used))                       return 2'b10;
        else if (f_match(wb, src, used))                        return 2'b11;
        else                                                    return 2'b00;
    endfunction

    assign w_allow_ex = (r_state != MD_WAIT);
    assign w_redir    = (r_state == RUN) & ex_redirect;
    assign w_ld_use   = (r_state == RUN) & r_ex.is_load &
                        (f_match(r_ex, id_rs1, id_rs1_used) | f_match(r_ex, id_rs2, id_rs2_used));
    assign w_md_busy  = r_ex.valid & r_ex.is_md & ~md_done;
    // Redirect kills the ID instruction, so any hazard it had is moot.
    assign w_run_ld   = ~w_redir & w_ld_use;
    assign w_run_md   = (r_state == RUN) & ~w_redir & ~w_ld_use & w_md_busy;
    assign w_md_hold  = (r_state == MD_WAIT) & ~md_done;
    assign w_stall    = w_run_ld | w_run_md | w_md_hold;

    assign w_id_ent = '{valid:   id_valid & ~w_redir,
                        rd:      id_rd,
                        wen:     id_wen,
                        is_load: id_is_load,
                        is_md:   id_is_md};

    // Outputs are forced low while reset is held, whatever the inputs do.
    assign fwd_a     = rst_n ? f_fwd(r_ex, r_mem, r_wb, w_allow_ex, id_rs1, id_rs1_used) : 2'b00;
    assign fwd_b     = rst_n ? f_fwd(r_ex, r_mem, r_wb, w_allow_ex, id_rs2, id_rs2_used) : 2'b00;
    assign stall_if  = rst_n & w_stall;
    assign stall_id  = rst_n & w_stall;
    assign flush_id  = rst_n & w_redir;
    assign bubble_ex = rst_n & (w_redir | w_run_ld);
    assign state     = r_state;
    assign md_err    = r_md_err;

    // Control FSM together with shadow-pipeline movement and the mul/div watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb     <= '0;
            r_cnt    <= '0;
            r_md_err <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_run_ld) begin
                        r_ex    <= '0;
                        r_mem   <= r_ex;
                        r_wb    <= r_mem;
                        r_state <= LD_STALL;
                    end else if (w_run_md) begin
                        r_mem   <= '0;
                        r_wb    <= r_mem;
                        r_cnt   <= '0;
                        r_state <= MD_WAIT;
                    end else begin
                        r_ex  <= w_id_ent;
                        r_mem <= r_ex;
                        r_wb  <= r_mem;
                    end
                end
                LD_STALL: begin
                    r_ex    <= w_id_ent;
                    r_mem   <= r_ex;
                    r_wb    <= r_mem;
                    r_state <= RUN;
                end
                MD_WAIT: begin
                    if (md_done) begin
                        r_ex    <= w_id_ent;
                        r_mem   <= r_ex;
                        r_wb    <= r_mem;
                        r_state <= RUN;
                    end else begin
                        r_mem <= '0;
                        r_wb  <= r_mem;
                        if (r_cnt != CNT_W'(MD_TIMEOUT))
                            r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(MD_TIMEOUT - 1))
                            r_md_err <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule
